// File: rtl/matmul_frame_ctrl_pkg.sv
// Shared constants and FSM state encodings for the host-link matmul sequencer.
// Word width follows MATMUL_DATA_W when the SOC defines it, else 16.
`ifndef MATMUL_DATA_W
`define MATMUL_DATA_W 16
`endif

package matmul_frame_ctrl_pkg;

  localparam int         DATA_W_DEF = `MATMUL_DATA_W;
  localparam logic [7:0] SOF_DEF    = 8'hFE;
  localparam logic [7:0] EOF_DEF    = 8'hFF;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    RX_PAY  = 3'd1,
    RX_CSUM = 3'd2,
    RX_EOF  = 3'd3,
    LOAD    = 3'd4,
    RUN     = 3'd5,
    TX      = 3'd6
  } state_t;

endpackage

// File: rtl/matmul_frame_ctrl_frame_tx_serializer.sv
// Result-frame serializer: SOF, result bytes MSB-first, optional XOR checksum, EOF.
// Optional feature: MATMUL_FRAME_CSUM_EN adds the checksum byte before EOF.
module frame_tx_serializer #(
  parameter int         DATA_W   = 16,
  parameter logic [7:0] SOF_BYTE = 8'hFE,
  parameter logic [7:0] EOF_BYTE = 8'hFF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [4*DATA_W-1:0] words,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ack,
  output logic                done
);

  localparam int NRES = 4 * DATA_W / 8;
`ifdef MATMUL_FRAME_CSUM_EN
  localparam int NTX = NRES + 3;
`else
  localparam int NTX = NRES + 2;
`endif
  localparam int IDX_W = $clog2(NTX);

  logic [4*DATA_W-1:0] res_q;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          nxt_byte;
  logic                last;
  int                  ni;

`ifdef MATMUL_FRAME_CSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < NRES; i++) csum = csum ^ res_q[8*i +: 8];
  end
`endif

  // Byte index 0 is SOF, 1..NRES the result bytes, then checksum (if any), then EOF.
  always_comb begin
    ni       = int'(idx) + 1;
    nxt_byte = EOF_BYTE;
    if (ni >= 1 && ni <= NRES) nxt_byte = res_q[4*DATA_W - 8*ni +: 8];
`ifdef MATMUL_FRAME_CSUM_EN
    else if (ni == NRES + 1) nxt_byte = csum;
`endif
  end

  assign last = (int'(idx) == NTX - 1);
  assign done = tx_valid & tx_ack & last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      res_q    <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (start) begin
      res_q    <= words;
      idx      <= '0;
      tx_data  <= SOF_BYTE;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ack) begin
      if (last) begin
        tx_valid <= 1'b0;
      end else begin
        idx     <= idx + 1'b1;
        tx_data <= nxt_byte;
      end
    end
  end

endmodule

// File: rtl/matmul_frame_ctrl.sv
// Host-link sequencer for the 2x2 systolic array: receive operand frame, run, return result frame.
// Optional feature: MATMUL_FRAME_CSUM_EN adds XOR checksum bytes in both directions.
//
// state   | meaning
// HUNT    | idle, discard bytes until SOF
// RX_PAY  | shifting in operand payload bytes
// RX_CSUM | checking payload checksum (checksum build only)
// RX_EOF  | expecting EOF; commits operands on success
// LOAD    | one-cycle sa_load strobe
// RUN     | sa_start held, waiting for sa_done or timeout
// TX      | serializer sending result frame
module matmul_frame_ctrl
  import matmul_frame_ctrl_pkg::*;
#(
  parameter int         DATA_W      = DATA_W_DEF,
  parameter logic [7:0] SOF_BYTE    = SOF_DEF,
  parameter logic [7:0] EOF_BYTE    = EOF_DEF,
  parameter int         RUN_TIMEOUT = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          rx_data,
  input  logic                rx_ready,
  output logic                rx_ack,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ack,
  output logic [4*DATA_W-1:0] blk_a,
  output logic [4*DATA_W-1:0] blk_b,
  output logic                sa_load,
  output logic                sa_start,
  input  logic                sa_done,
  input  logic [4*DATA_W-1:0] sa_result,
  output logic                busy,
  output logic                err
);

  localparam int WB    = DATA_W / 8;
  localparam int NPAY  = 8 * WB;
  localparam int CNT_W = $clog2(NPAY);
  localparam int RUN_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    byte_cnt;
  logic [8*DATA_W-1:0] shadow;
  logic [RUN_W-1:0]    run_cnt;
  logic                last_pay, run_to, tx_start, tx_done;
`ifdef MATMUL_FRAME_CSUM_EN
  logic [7:0]          csum_acc;
`endif

  assign last_pay = (byte_cnt == CNT_W'(NPAY - 1));
  assign run_to   = (RUN_TIMEOUT != 0) && (run_cnt == RUN_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (rx_ready && rx_data == SOF_BYTE) state_nxt = RX_PAY;
`ifdef MATMUL_FRAME_CSUM_EN
      RX_PAY:  if (rx_ready && last_pay) state_nxt = RX_CSUM;
      RX_CSUM: if (rx_ready) state_nxt = (rx_data == csum_acc) ? RX_EOF : HUNT;
`else
      RX_PAY:  if (rx_ready && last_pay) state_nxt = RX_EOF;
`endif
      RX_EOF:  if (rx_ready) state_nxt = (rx_data == EOF_BYTE) ? LOAD : HUNT;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (sa_done)     state_nxt = TX;
        else if (run_to) state_nxt = HUNT;
      end
      TX:      if (tx_done) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    rx_ack   = rx_ready & (state inside {HUNT, RX_PAY, RX_CSUM, RX_EOF});
    sa_load  = (state == LOAD);
    sa_start = (state == RUN);
    busy     = (state != HUNT);
    tx_start = (state == RUN) & sa_done;
  end

  // Operands are staged in shadow and only committed to blk_a/blk_b by a good EOF.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      byte_cnt <= '0;
      shadow   <= '0;
      run_cnt  <= '0;
      blk_a    <= '0;
      blk_b    <= '0;
      err      <= 1'b0;
`ifdef MATMUL_FRAME_CSUM_EN
      csum_acc <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        HUNT: if (rx_ready && rx_data == SOF_BYTE) begin
          byte_cnt <= '0;
`ifdef MATMUL_FRAME_CSUM_EN
          csum_acc <= '0;
`endif
        end
        RX_PAY: if (rx_ready) begin
          shadow   <= {shadow[8*DATA_W-9:0], rx_data};
          byte_cnt <= byte_cnt + 1'b1;
`ifdef MATMUL_FRAME_CSUM_EN
          csum_acc <= csum_acc ^ rx_data;
`endif
        end
`ifdef MATMUL_FRAME_CSUM_EN
        RX_CSUM: if (rx_ready && rx_data != csum_acc) err <= 1'b1;
`endif
        RX_EOF: if (rx_ready) begin
          if (rx_data == EOF_BYTE) begin
            blk_a <= shadow[8*DATA_W-1 -: 4*DATA_W];
            blk_b <= shadow[4*DATA_W-1:0];
          end else begin
            err <= 1'b1;
          end
        end
        LOAD: run_cnt <= '0;
        RUN: if (!sa_done) begin
          if (run_to) err <= 1'b1;
          else        run_cnt <= run_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  frame_tx_serializer #(
    .DATA_W   (DATA_W),
    .SOF_BYTE (SOF_BYTE),
    .EOF_BYTE (EOF_BYTE)
  ) u_tx (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (tx_start),
    .words    (sa_result),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_matmul_frame_ctrl.sv
// Directed bench for matmul_frame_ctrl: table of frame scenarios plus reset/idle sequences.
module tb_matmul_frame_ctrl;

  localparam int DW = 16;
  localparam int TO = 16;
`ifdef MATMUL_FRAME_CSUM_EN
  localparam int NTX = 11;
`else
  localparam int NTX = 10;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          rx_ack;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ack = 1'b0;
  logic [4*DW-1:0] blk_a, blk_b;
  logic          sa_load, sa_start;
  logic          sa_done = 1'b0;
  logic [4*DW-1:0] sa_result = '0;
  logic          busy, err;

  always #5 CLK = ~CLK;

  matmul_frame_ctrl #(.DATA_W(DW), .RUN_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .blk_a(blk_a), .blk_b(blk_b),
    .sa_load(sa_load), .sa_start(sa_start), .sa_done(sa_done), .sa_result(sa_result),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic [63:0] a, b, res;
    logic [7:0]  eof;
    int          junk, done_after, ack_delay, rst_after;
    logic [63:0] exp_a, exp_b;
    int          exp_load, exp_start, exp_err, exp_tx;
  } vec_t;

  vec_t vecs[8];
  int n_chk = 0, n_pass = 0;

  int n_load, n_start, n_err, first_load, first_start;
  bit unstable, ack_busy, to_flag;
  logic [7:0] txq[$];
  logic [7:0] expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_data = b; rx_ready = 1'b1; #1;
    while (!rx_ack && k < 64) begin @(posedge CLK); #1; k++; end
    if (!rx_ack) chk("rx_ack_wait", {63'd0, rx_ack}, 64'd1);
    @(posedge CLK); #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input int junk, input logic [63:0] a, input logic [63:0] b,
                            input logic [7:0] eofb);
    logic [127:0] pay = {a, b};
    logic [7:0] cs = '0;
    if (junk != 0) begin send_byte(8'h11); send_byte(8'h22); send_byte(8'hFF); end
    send_byte(8'hFE);
    for (int i = 0; i < 16; i++) begin
      send_byte(pay[127-8*i -: 8]);
      cs = cs ^ pay[127-8*i -: 8];
    end
`ifdef MATMUL_FRAME_CSUM_EN
    send_byte(cs);
`endif
    send_byte(eofb);
  endtask

  // Plays the array and the UART tx side after the frame's last byte until busy drops.
  task automatic monitor(input int done_after, input int ack_delay, input int rst_after);
    int start_cnt = 0, wait_c = 0;
    bit pending = 0;
    logic [7:0] held = '0;
    n_load = 0; n_start = 0; n_err = 0; first_load = -1; first_start = -1;
    unstable = 0; ack_busy = 0; to_flag = 1; txq.delete();
    rx_data = 8'hFE; rx_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (sa_load) begin n_load++; if (first_load < 0) first_load = c; end
      if (sa_start) begin n_start++; if (first_start < 0) first_start = c; end
      if (err) n_err++;
      if (busy && rx_ack) ack_busy = 1;
      if (pending && (!tx_valid || tx_data != held)) unstable = 1;
      if (!busy) begin to_flag = 0; break; end
      sa_done = sa_start && done_after >= 0 && start_cnt == done_after;
      if (sa_start) start_cnt++;
      tx_ack = 1'b0; pending = 0;
      if (tx_valid) begin
        if (wait_c == ack_delay) begin
          tx_ack = 1'b1; txq.push_back(tx_data); wait_c = 0;
          if (rst_after > 0 && txq.size() == rst_after) RESET = 1'b1;
        end else begin
          wait_c++; pending = 1; held = tx_data;
        end
      end
    end
    rx_ready = 1'b0; sa_done = 1'b0; tx_ack = 1'b0; RESET = 1'b0;
    chk("monitor_budget", {63'd0, to_flag}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h0002_0003_0004_0005, 64'h0001_0000_0000_0001, 64'h0002_0003_0004_0005, 8'hFF,
                0, 3, 0, 0, 64'h0002_0003_0004_0005, 64'h0001_0000_0000_0001, 1, 4, 0, 1};
    vecs[1] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h0, 8'h7F,
                0, 3, 0, 0, 64'h0002_0003_0004_0005, 64'h0001_0000_0000_0001, 0, 0, 1, 0};
    vecs[2] = '{64'hDEAD_BEEF_0102_0304, 64'hFFFF_0000_8000_0001, 64'h1234_5678_9ABC_DEF0, 8'hFF,
                1, 0, 1, 0, 64'hDEAD_BEEF_0102_0304, 64'hFFFF_0000_8000_0001, 1, 1, 0, 1};
    vecs[3] = '{64'h0A0B_0C0D_0E0F_1011, 64'h2021_2223_2425_2627, 64'hA5A5_5A5A_0001_FF00, 8'hFF,
                0, 7, 5, 0, 64'h0A0B_0C0D_0E0F_1011, 64'h2021_2223_2425_2627, 1, 8, 0, 1};
    vecs[4] = '{64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
                0, -1, 0, 0, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 1, 16, 1, 0};
    vecs[5] = '{64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888, 64'h0, 8'hFE,
                0, 3, 0, 0, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 0, 0, 1, 0};
    vecs[6] = '{64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF,
                0, 2, 0, 3, 64'h0, 64'h0, 1, 3, 0, 1};
    vecs[7] = '{64'h7FFF_8000_0000_FFFF, 64'h0003_0002_0001_0000, 64'h0102_0304_0506_0708, 8'hFF,
                1, 1, 2, 0, 64'h7FFF_8000_0000_FFFF, 64'h0003_0002_0001_0000, 1, 2, 0, 1};

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
    chk("rst_blk_a", blk_a, 64'd0);
    chk("rst_blk_b", blk_b, 64'd0);
    chk("rst_sa_load", {63'd0, sa_load}, 64'd0);
    chk("rst_sa_start", {63'd0, sa_start}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);

    // Stray tx_ack while idle must not start anything.
    tx_ack = 1'b1;
    @(negedge CLK);
    tx_ack = 1'b0;
    @(negedge CLK);
    chk("idle_ack_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("idle_ack_busy", {63'd0, busy}, 64'd0);

    // A junk byte in HUNT is acked and dropped.
    rx_data = 8'h33; rx_ready = 1'b1; #1;
    chk("hunt_rx_ack", {63'd0, rx_ack}, 64'd1);
    @(negedge CLK);
    rx_ready = 1'b0;
    @(negedge CLK);
    chk("hunt_junk_busy", {63'd0, busy}, 64'd0);
    @(posedge CLK); #1;

    for (int v = 0; v < 8; v++) begin
      int exp_ntx;
      sa_result = vecs[v].res;
      send_frame(vecs[v].junk, vecs[v].a, vecs[v].b, vecs[v].eof);
      monitor(vecs[v].done_after, vecs[v].ack_delay, vecs[v].rst_after);

      expq.delete();
      expq.push_back(8'hFE);
      for (int i = 0; i < 8; i++) expq.push_back(vecs[v].res[63-8*i -: 8]);
`ifdef MATMUL_FRAME_CSUM_EN
      begin
        logic [7:0] cs = '0;
        for (int i = 0; i < 8; i++) cs = cs ^ vecs[v].res[63-8*i -: 8];
        expq.push_back(cs);
      end
`endif
      expq.push_back(8'hFF);
      exp_ntx = (vecs[v].rst_after > 0) ? vecs[v].rst_after : (vecs[v].exp_tx != 0 ? NTX : 0);

      chk($sformatf("v%0d_blk_a", v), blk_a, vecs[v].exp_a);
      chk($sformatf("v%0d_blk_b", v), blk_b, vecs[v].exp_b);
      chk($sformatf("v%0d_n_load", v), 64'(n_load), 64'(vecs[v].exp_load));
      chk($sformatf("v%0d_n_start", v), 64'(n_start), 64'(vecs[v].exp_start));
      chk($sformatf("v%0d_n_err", v), 64'(n_err), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_n_tx", v), 64'(txq.size()), 64'(exp_ntx));
      chk($sformatf("v%0d_tx_stable", v), {63'd0, unstable}, 64'd0);
      chk($sformatf("v%0d_rx_ack_busy", v), {63'd0, ack_busy}, 64'd0);
      chk($sformatf("v%0d_tx_valid_end", v), {63'd0, tx_valid}, 64'd0);
      if (vecs[v].exp_load != 0) begin
        chk($sformatf("v%0d_load_lat", v), 64'(first_load), 64'd0);
        chk($sformatf("v%0d_start_lat", v), 64'(first_start), 64'd1);
      end
      for (int i = 0; i < txq.size() && i < exp_ntx; i++)
        chk($sformatf("v%0d_tx_byte%0d", v, i), {56'd0, txq[i]}, {56'd0, expq[i]});
      @(posedge CLK); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
